// File: rtl/tank_pkg.sv
// Shared types and constants for the irrigation tank model.
package tank_pkg;

  typedef enum logic [2:0] {
    EMPTY    = 3'd0,
    FILLING  = 3'd1,
    DRAINING = 3'd2,
    STEADY   = 3'd3,
    FULL     = 3'd4
  } tank_state_e;

  // fault_sel codes
  localparam logic [1:0] FAULT_NONE = 2'd0;
  localparam logic [1:0] FAULT_L    = 2'd1;
  localparam logic [1:0] FAULT_M    = 2'd2;
  localparam logic [1:0] FAULT_H    = 2'd3;

  // Default sensor thresholds
  localparam int unsigned L_TH_DEFAULT = 50;
  localparam int unsigned M_TH_DEFAULT = 100;
  localparam int unsigned H_TH_DEFAULT = 150;
  localparam int unsigned HYST_DEFAULT = 4;

  // Hysteretic float switch: set at TH, clear below TH-HYST, otherwise hold.
  function automatic logic sensor_next(logic held, int unsigned lvl, int unsigned th,
                                       int unsigned hyst);
    if (lvl >= th) return 1'b1;
    if (lvl < th - hyst) return 1'b0;
    return held;
  endfunction

endpackage

// File: rtl/tank_tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1 and flags the terminal count as tick.
module tank_tick_gen #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clock,
  input  logic Rst,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count_q;

  assign tick = (count_q == CW'(TICK_DIV - 1));

  // Free-running modulo counter, cleared by reset.
  always_ff @(posedge clock) begin
    if (!Rst) begin
      count_q <= '0;
    end else if (tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/tank_level_model.sv
// Behavioural water tank: integrates actuator flows into a level and derives
// hysteretic L/M/H float sensors. Optional sensor fault injection is enabled
// by defining TANK_SENSOR_FAULT_EN (adds fault_sel / fault_val inputs).
module tank_level_model
  import tank_pkg::*;
#(
  parameter int unsigned LEVEL_W    = 8,
  parameter int unsigned CAPACITY   = 200,
  parameter int unsigned INIT_LEVEL = 0,
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned FILL_STEP  = 5,
  parameter int unsigned BS_DRAIN   = 3,
  parameter int unsigned VS_DRAIN   = 1,
  parameter int unsigned L_TH       = L_TH_DEFAULT,
  parameter int unsigned M_TH       = M_TH_DEFAULT,
  parameter int unsigned H_TH       = H_TH_DEFAULT,
  parameter int unsigned HYST       = HYST_DEFAULT
) (
  input  logic               clock,
  input  logic               Rst,
  input  logic               Ve,
  input  logic               Bs,
  input  logic               Vs,
`ifdef TANK_SENSOR_FAULT_EN
  input  logic [1:0]         fault_sel,
  input  logic               fault_val,
`endif
  output logic               L,
  output logic               M,
  output logic               H,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow,
  output logic               dry_run,
  output logic [2:0]         state
);

  // Elaboration-time parameter sanity checks
  if (INIT_LEVEL > CAPACITY) begin : g_bad_init
    $error("tank_level_model: INIT_LEVEL exceeds CAPACITY");
  end
  if (TICK_DIV < 2) begin : g_bad_div
    $error("tank_level_model: TICK_DIV must be at least 2");
  end
  if (CAPACITY >= (1 << LEVEL_W)) begin : g_bad_width
    $error("tank_level_model: CAPACITY does not fit in LEVEL_W bits");
  end
  if (!(L_TH > HYST) || !(L_TH + HYST < M_TH) || !(M_TH + HYST < H_TH) ||
      !(H_TH <= CAPACITY)) begin : g_bad_th
    $error("tank_level_model: inconsistent sensor thresholds");
  end

  localparam int unsigned SW = LEVEL_W + 2;
  localparam logic signed [SW-1:0] FILL_S = SW'(FILL_STEP);
  localparam logic signed [SW-1:0] BS_S   = SW'(BS_DRAIN);
  localparam logic signed [SW-1:0] VS_S   = SW'(VS_DRAIN);
  localparam logic signed [SW-1:0] CAP_S  = SW'(CAPACITY);

  logic tick;

  tank_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clock(clock),
    .Rst  (Rst),
    .tick (tick)
  );

  logic [LEVEL_W-1:0]    level_q, level_d;
  tank_state_e           state_q, state_d;
  logic                  overflow_q, overflow_d;
  logic                  dry_run_q, dry_run_d;
  logic [2:0]            sens_q, sens_d;  // true hysteretic {H, M, L}
  logic [2:0]            out_q, out_d;    // sensor outputs as presented
  logic signed [SW-1:0]  delta, sum;

  // Net flow for this step and the unsaturated next level.
  always_comb begin
    delta = '0;
    if (Ve) delta = delta + FILL_S;
    if (Bs) delta = delta - BS_S;
    if (Vs) delta = delta - VS_S;
    sum = signed'({2'b00, level_q}) + delta;
  end

  // Saturating level update and state classification, only on tick.
  always_comb begin
    level_d    = level_q;
    state_d    = state_q;
    overflow_d = 1'b0;
    dry_run_d  = 1'b0;
    if (tick) begin
      if (sum > CAP_S) begin
        level_d    = LEVEL_W'(CAPACITY);
        overflow_d = 1'b1;
      end else if (sum[SW-1]) begin
        level_d   = '0;
        dry_run_d = Bs | Vs;
      end else begin
        level_d = sum[LEVEL_W-1:0];
      end
      // Level extremes take priority, so a saturated step never reads as a flow.
      if (level_d == '0) begin
        state_d = EMPTY;
      end else if (level_d == LEVEL_W'(CAPACITY)) begin
        state_d = FULL;
      end else if (delta[SW-1]) begin
        state_d = DRAINING;
      end else if (delta != '0) begin
        state_d = FILLING;
      end else begin
        state_d = STEADY;
      end
    end
  end

  // Sensors follow the registered level, then optional fault forcing.
  always_comb begin
    sens_d[0] = sensor_next(sens_q[0], 32'(level_q), L_TH, HYST);
    sens_d[1] = sensor_next(sens_q[1], 32'(level_q), M_TH, HYST);
    sens_d[2] = sensor_next(sens_q[2], 32'(level_q), H_TH, HYST);
    out_d     = sens_d;
`ifdef TANK_SENSOR_FAULT_EN
    case (fault_sel)
      FAULT_L: out_d[0] = fault_val;
      FAULT_M: out_d[1] = fault_val;
      FAULT_H: out_d[2] = fault_val;
      default: ;
    endcase
`endif
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!Rst) begin
      level_q    <= LEVEL_W'(INIT_LEVEL);
      state_q    <= STEADY;
      overflow_q <= 1'b0;
      dry_run_q  <= 1'b0;
      sens_q     <= '0;
      out_q      <= '0;
    end else begin
      level_q    <= level_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
      dry_run_q  <= dry_run_d;
      sens_q     <= sens_d;
      out_q      <= out_d;
    end
  end

  assign level    = level_q;
  assign state    = state_q;
  assign overflow = overflow_q;
  assign dry_run  = dry_run_q;
  assign L        = out_q[0];
  assign M        = out_q[1];
  assign H        = out_q[2];

endmodule

// File: tb/tb_tank_level_model.sv
// Scoreboard bench for tank_level_model with TICK_DIV=4. The driver runs an
// arithmetic reference model per clock edge and queues expected outputs; a
// monitor on the falling edge pops and compares.
module tb_tank_level_model;
  import tank_pkg::*;

  localparam int TDIV = 4;
  localparam int CAP  = 200;
  localparam int HYS  = 4;

  logic       clock = 1'b0;
  logic       rst, ve, bs, vs;
  logic [1:0] fault_sel;
  logic       fault_val;
  logic       L, M, H, overflow, dry_run;
  logic [7:0] level;
  logic [2:0] state;

  always #5 clock = ~clock;

  tank_level_model #(
    .TICK_DIV(TDIV)
  ) dut (
    .clock   (clock),
    .Rst     (rst),
    .Ve      (ve),
    .Bs      (bs),
    .Vs      (vs),
`ifdef TANK_SENSOR_FAULT_EN
    .fault_sel(fault_sel),
    .fault_val(fault_val),
`endif
    .L       (L),
    .M       (M),
    .H       (H),
    .level   (level),
    .overflow(overflow),
    .dry_run (dry_run),
    .state   (state)
  );

  typedef struct {
    int       lvl;
    int       st;
    bit       ovf;
    bit       dry;
    bit [2:0] sens;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  int       m_level = 0;
  int       m_state = int'(STEADY);
  int       m_run = 0;
  bit       m_ovf = 0, m_dry = 0;
  bit [2:0] m_true = '0, m_out = '0;
  int       th[3] = '{50, 100, 150};

  task automatic model_edge(input bit r, input bit a, input bit b, input bit c,
                            input bit [1:0] fs, input bit fv);
    int n;
    int d;
    bit [2:0] nt;
    exp_t e;
    if (!r) begin
      m_run = 0; m_level = 0; m_state = int'(STEADY);
      m_true = '0; m_out = '0; m_ovf = 0; m_dry = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_level >= th[i]) nt[i] = 1'b1;
        else if (m_level < th[i] - HYS) nt[i] = 1'b0;
        else nt[i] = m_true[i];
      end
      m_true = nt;
      m_out  = nt;
      if (fs != 2'd0) m_out[fs - 2'd1] = fv;
      m_run++;
      m_ovf = 0; m_dry = 0;
      if (m_run % TDIV == 0) begin
        d = (a ? 5 : 0) - (b ? 3 : 0) - (c ? 1 : 0);
        n = m_level + d;
        if (n > CAP) begin m_level = CAP; m_ovf = 1; end
        else if (n < 0) begin m_level = 0; m_dry = b | c; end
        else m_level = n;
        if (m_level == 0) m_state = int'(EMPTY);
        else if (m_level == CAP) m_state = int'(FULL);
        else if (d > 0) m_state = int'(FILLING);
        else if (d < 0) m_state = int'(DRAINING);
        else m_state = int'(STEADY);
      end
    end
    e.lvl = m_level; e.st = m_state; e.ovf = m_ovf; e.dry = m_dry; e.sens = m_out;
    q.push_back(e);
  endtask

  // One clock: drive inputs after the falling edge and queue the expectation.
  task automatic cycle(input bit r, input bit a, input bit b, input bit c);
    @(negedge clock);
    #1;
    rst = r; ve = a; bs = b; vs = c;
    model_edge(r, a, b, c, fault_sel, fault_val);
  endtask

  task automatic steps(input int n, input bit a, input bit b, input bit c);
    repeat (n * TDIV) cycle(1'b1, a, b, c);
  endtask

  task automatic report(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: compare queued expectations on the falling edge.
  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      report("level", (^level === 1'bx) ? -1 : int'(level), e.lvl);
      report("state", (^state === 1'bx) ? -1 : int'(state), e.st);
      report("pulses", (^{overflow, dry_run} === 1'bx) ? -1 : int'({overflow, dry_run}),
             int'({e.ovf, e.dry}));
      report("sensors_hml", (^{H, M, L} === 1'bx) ? -1 : int'({H, M, L}), int'(e.sens));
    end
  end

  initial begin
    rst = 1'b0; ve = 0; bs = 0; vs = 0; fault_sel = 2'd0; fault_val = 1'b0;
    repeat (3) cycle(1'b0, 0, 0, 0);
    // Fill from empty past capacity
    steps(45, 1, 0, 0);
    // Drain to empty through all thresholds, then dry-run pulses
    steps(55, 0, 1, 1);
    // Hysteresis: fill to 55, drain with drip valve only
    steps(11, 1, 0, 0);
    steps(12, 0, 0, 1);
    // Net flow: all on, then Ve+Bs
    steps(12, 1, 0, 0);
    steps(5, 1, 1, 1);
    steps(5, 1, 1, 0);
    // Dry run with pump only
    steps(45, 0, 1, 0);
    // Reset mid-operation at an uneven phase
    steps(20, 1, 0, 0);
    repeat (3) cycle(1'b1, 1, 0, 0);
    cycle(1'b0, 1, 0, 0);
    steps(6, 1, 0, 0);
`ifdef TANK_SENSOR_FAULT_EN
    steps(26, 1, 0, 0);
    fault_sel = FAULT_M; fault_val = 1'b0;
    steps(2, 0, 0, 0);
    fault_sel = FAULT_NONE;
    steps(2, 0, 0, 0);
`endif
    // Random actuators changing every cycle, occasional reset
    for (int i = 0; i < 3000; i++) begin
`ifdef TANK_SENSOR_FAULT_EN
      if ($urandom_range(0, 15) == 0) begin
        fault_sel = 2'($urandom_range(0, 3));
        fault_val = 1'($urandom_range(0, 1));
      end
`endif
      cycle(($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end
    @(negedge clock);
    #2;
    report("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
